// File: rtl/seq_detect_sched_if.sv
// seq_detect_sched_if: serial channel lanes and match report; SEQ_DETECT_SCHED_CNT_EN adds counter ports
interface seq_detect_sched_if #(
    parameter int NCH = 4
`ifdef SEQ_DETECT_SCHED_CNT_EN
    , parameter int CW = 8
`endif
);
    localparam int CHW = $clog2(NCH);
    logic [NCH-1:0] in;
    logic [NCH-1:0] in_valid;
    logic [NCH-1:0] in_ready;
    logic out;
    logic [CHW-1:0] out_ch;
`ifdef SEQ_DETECT_SCHED_CNT_EN
    logic [NCH-1:0] cnt_clr;
    logic [NCH*CW-1:0] match_cnt;
    modport master(output in, in_valid, cnt_clr, input in_ready, out, out_ch, match_cnt);
    modport slave(input in, in_valid, cnt_clr, output in_ready, out, out_ch, match_cnt);
`else
    modport master(output in, in_valid, input in_ready, out, out_ch);
    modport slave(input in, in_valid, output in_ready, out, out_ch);
`endif
endinterface

// File: rtl/seq_detect_sched.sv
// seq_detect_sched: round-robin shared "101" Mealy detector over NCH lanes; SEQ_DETECT_SCHED_CNT_EN adds match counters
module seq_detect_sched #(
    parameter int NCH = 4
`ifdef SEQ_DETECT_SCHED_CNT_EN
    , parameter int CW = 8
`endif
) (
    input logic clk,
    input logic rst,
    seq_detect_sched_if.slave bus
);
    localparam int CHW = $clog2(NCH);
    typedef enum logic [1:0] {S0 = 2'b00, S1 = 2'b01, S2 = 2'b10} state_e;
    logic [1:0] ctx_q [NCH];
    logic [1:0] ctx_d [NCH];
    logic [CHW-1:0] rr_q, rr_d, out_ch_q, out_ch_d, g;
    logic out_q, out_d, gv, b, match;
    state_e cur, nxt;
    always_comb begin
        g = '0;
        gv = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (!gv && !rst && bus.in_valid[(int'(rr_q) + i) % NCH]) begin
                gv = 1'b1;
                g = CHW'((int'(rr_q) + i) % NCH);
            end
        end
        bus.in_ready = gv ? {{(NCH-1){1'b0}}, 1'b1} << g : '0;
        b = bus.in[g];
        // the unreachable 11 encoding decodes as idle
        cur = ctx_q[g] == 2'b11 ? S0 : state_e'(ctx_q[g]);
        nxt = b ? S1 : (cur == S1 ? S2 : S0);
        match = gv && b && cur == S2;
        ctx_d = ctx_q;
        if (gv) ctx_d[g] = nxt;
        rr_d = !gv ? rr_q : (int'(g) == NCH - 1 ? '0 : g + 1'b1);
        out_d = match;
        out_ch_d = match ? g : out_ch_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            ctx_q <= '{default: 2'b00};
            rr_q <= '0;
            out_q <= 1'b0;
            out_ch_q <= '0;
        end else begin
            ctx_q <= ctx_d;
            rr_q <= rr_d;
            out_q <= out_d;
            out_ch_q <= out_ch_d;
        end
    end
    assign bus.out = out_q;
    assign bus.out_ch = out_ch_q;
`ifdef SEQ_DETECT_SCHED_CNT_EN
    logic [CW-1:0] cnt_q [NCH];
    logic [CW-1:0] cnt_d [NCH];
    always_comb begin
        for (int c = 0; c < NCH; c++)
            cnt_d[c] = bus.cnt_clr[c] ? '0 :
                       (match && int'(g) == c && cnt_q[c] != '1) ? cnt_q[c] + 1'b1 : cnt_q[c];
    end
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '{default: '0};
        else cnt_q <= cnt_d;
    end
    for (genvar c = 0; c < NCH; c++) begin : g_cnt
        assign bus.match_cnt[c*CW +: CW] = cnt_q[c];
    end
`endif
endmodule

// File: tb/tb_seq_detect_sched.sv
// tb_seq_detect_sched: scoreboard bench; per-lane history model predicts grants, matches and counters
module tb_seq_detect_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
`ifdef SEQ_DETECT_SCHED_CNT_EN
    seq_detect_sched_if #(.NCH(4), .CW(2)) bus();
    seq_detect_sched #(.NCH(4), .CW(2)) dut(.clk(clk), .rst(rst), .bus(bus));
`else
    seq_detect_sched_if #(.NCH(4)) bus();
    seq_detect_sched #(.NCH(4)) dut(.clk(clk), .rst(rst), .bus(bus));
`endif
    typedef struct packed {
        logic o;
        logic [1:0] ch;
        logic [7:0] cnt;
    } exp_t;
    exp_t sb[$];
    int n_chk = 0;
    int n_pass = 0;
    logic [31:0] pend_bits [4];
    int pend_n [4];
    logic [2:0] hist [4];
    int cnt [4];
    int ptr = 0;
    logic [1:0] m_ch = 2'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic compare_one();
        exp_t e;
        e = sb.pop_front();
        chk("out", 32'(bus.out), 32'(e.o));
        chk("out_ch", 32'(bus.out_ch), 32'(e.ch));
`ifdef SEQ_DETECT_SCHED_CNT_EN
        chk("match_cnt", 32'(bus.match_cnt), 32'(e.cnt));
`endif
    endtask

    task automatic load(input int c, input logic [15:0] pat, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            pend_bits[c][pend_n[c]] = pat[i];
            pend_n[c]++;
        end
    endtask

    task automatic step(input logic r, input logic [3:0] clr);
        exp_t e;
        logic [3:0] v, d, gnt;
        logic [2:0] h;
        logic m;
        int g;
        @(negedge clk);
        if (sb.size() > 0) compare_one();
        for (int c = 0; c < 4; c++) begin
            v[c] = pend_n[c] > 0;
            d[c] = pend_bits[c][0];
        end
        rst = r;
        bus.in_valid = v;
        bus.in = d;
`ifdef SEQ_DETECT_SCHED_CNT_EN
        bus.cnt_clr = clr;
`endif
        g = -1;
        if (!r) for (int i = 0; i < 4; i++) if (g < 0 && v[(ptr + i) % 4]) g = (ptr + i) % 4;
        gnt = g >= 0 ? 4'b0001 << g : 4'b0000;
        #1 chk("in_ready", 32'(bus.in_ready), 32'(gnt));
        m = 1'b0;
        if (r) begin
            for (int c = 0; c < 4; c++) begin
                hist[c] = 3'b000;
                cnt[c] = 0;
            end
            ptr = 0;
            m_ch = 2'd0;
        end else begin
            if (g >= 0) begin
                h = {hist[g][1:0], d[g]};
                m = h == 3'b101;
                hist[g] = h;
                ptr = (g + 1) % 4;
                if (m) m_ch = 2'(g);
                pend_bits[g] = pend_bits[g] >> 1;
                pend_n[g]--;
            end
            for (int c = 0; c < 4; c++)
                if (clr[c]) cnt[c] = 0;
                else if (m && c == g && cnt[c] < 3) cnt[c]++;
        end
        e.o = m;
        e.ch = m_ch;
        for (int c = 0; c < 4; c++) e.cnt[c*2 +: 2] = 2'(cnt[c]);
        sb.push_back(e);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'b0000);
    endtask

    initial begin
        for (int c = 0; c < 4; c++) begin
            pend_bits[c] = '0;
            pend_n[c] = 0;
            hist[c] = 3'b000;
            cnt[c] = 0;
        end
        bus.in = '0;
        bus.in_valid = '0;
`ifdef SEQ_DETECT_SCHED_CNT_EN
        bus.cnt_clr = '0;
`endif
        step(1'b1, 4'b0000);
        step(1'b1, 4'b0000);
        load(0, 16'b10101, 5);
        run(7);
        step(1'b1, 4'b0000);
        for (int c = 0; c < 4; c++) load(c, 16'b101, 3);
        run(14);
        load(1, 16'b10, 2);
        load(2, 16'b00, 2);
        run(5);
        load(1, 16'b1, 1);
        run(2);
        load(2, 16'b1, 1);
        run(2);
        load(3, 16'b1, 1);
        run(6);
        load(3, 16'b0, 1);
        run(3);
        load(3, 16'b1, 1);
        run(3);
        load(0, 16'b10, 2);
        run(2);
        step(1'b1, 4'b0000);
        load(0, 16'b1, 1);
        run(2);
        load(0, 16'b01, 2);
        run(3);
        load(2, 16'b10101010101, 11);
        run(13);
        load(2, 16'b01, 2);
        step(1'b0, 4'b0000);
        step(1'b0, 4'b0100);
        run(2);
        load(2, 16'b01, 2);
        run(3);
        while (sb.size() > 0) begin
            @(negedge clk);
            compare_one();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/seq_detect_sched.md
# seq_detect_sched

Time-multiplexed "101" sequence-detection scheduler: shares one Mealy match engine among NCH serial input channels. A round-robin arbiter grants one channel per cycle. The engine advances that channel's saved FSM context and reports matches tagged with the channel index. It sits between the serial front-end lanes and the event/interrupt logic, replacing NCH separate detector instances.

## Interface
- NCH, 4: number of serial channels; legal 2..16.
- CW, 8: width of each per-channel match counter (only with the counter feature).
- CHW, $clog2(NCH): channel-index width (derived, not overridden).

- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in  input  NCH  serial data bit, one per channel.
- in_valid  input  NCH  channel c has a bit pending.
- in_ready  output  NCH  one-hot grant; combinational from in_valid, rr_ptr and rst; a bit transfers when in_valid[c] & in_ready[c].
- out  output  1  registered match pulse.
- out_ch  output  CHW  channel that produced the match; valid when out=1.
- cnt_clr  input  NCH  per-channel counter clear (counter build only).
- match_cnt  output  NCH*CW  packed per-channel saturating match counts; channel c is at [c*CW +: CW] (counter build only).

## Operation
- Per-channel context ctx[c], 2 bits: S0=00 (idle), S1=01 (seen "1"), S2=10 ("10"). The encoding 11 is unreachable; if it occurs, treat it as S0.
- Arbiter: the grant goes to the first channel with in_valid set, searching from rr_ptr upward with wrap NCH-1 -> 0.
  - On a grant to channel g, rr_ptr <= g+1 (mod NCH).
  - With no valid channel there is no grant and rr_ptr holds.
- Engine, applied only to the granted channel g with bit b. The detection overlaps ("10101" gives two matches).
  - S0: b=1 -> S1; b=0 -> S0.
  - S1: b=1 -> S1; b=0 -> S2.
  - S2: b=1 -> S1 with match; b=0 -> S0.
- Ungranted channels keep their context unchanged. A channel holding in_valid is not consumed until it is granted; the source holds the bit stable.
- Match reporting:
  - out <= match and out_ch <= g.
  - With no match, out <= 0 and out_ch holds its last value.
- Reset values: ctx all S0, rr_ptr 0, out 0, out_ch 0, match_cnt all 0.
- During rst, in_ready is all 0 and no bit is consumed.

## Timing
- Transfer in cycle N -> out/out_ch valid in cycle N+1; out is a one-cycle pulse per match.
- Throughput: one bit per cycle in aggregate.
- Fairness: with all NCH valid continuously, each channel is granted exactly once every NCH cycles.
- A single active channel is granted every cycle.
- Reset mid-sequence: partial patterns are discarded. The first post-reset "101" on any channel is needed to match; no match is carried across reset.
- A match in the cycle rst is asserted is dropped: out=0 in the following cycle.

## Configuration
- SEQ_DETECT_SCHED_CNT_EN defined: the match_cnt output and cnt_clr input exist.
  - Counter c increments on each match from channel c and saturates at 2^CW-1.
  - When cnt_clr[c] and a match on c occur in the same cycle, the clear wins and the counter becomes 0.
  - The counter updates in the same edge as out.
- Not defined: match_cnt and cnt_clr ports are absent; no counter logic is generated; all other behaviour is identical.

## Test plan
- Reset then single channel: ch0 valid continuously with bits 1,0,1,0,1 and others idle.
  - Grants every cycle.
  - out=1, out_ch=0 one cycle after the 3rd and 5th bits; out=0 elsewhere.
- Full contention, NCH=4: all channels valid, each sending 1,0,1.
  - Grant order is 0,1,2,3 repeating.
  - Matches on ch0..ch3 occur in consecutive cycles 9..12 after release of reset (transfer cycles 8..11).
- Context isolation: interleave ch1 sending "1","0" with ch2 sending "0","0", then ch1 sends "1".
  - Only ch1 matches; ch2's context stays S0.
- Idle gaps: ch3 sends 1, is idle 5 cycles, sends 0, is idle, sends 1.
  - A match is still reported (context held); rr_ptr is unchanged during the idle cycles.
- Reset mid-pattern: ch0 sends 1,0; rst for 1 cycle; then ch0 sends 1.
  - No match; in_ready=0 during rst.
  - A following 0,1 then produces a match.
- Counter (CNT_EN, CW=2): 5 matches on ch2 -> match_cnt[2] saturates at 3.
  - cnt_clr[2] asserted coincident with a match -> 0 next cycle.
